// File: rtl/fec_dec_pingpong_buffer.sv
// fec_dec_pingpong_buffer: two-bank frame buffer between the demodulator
// symbol stream and the FEC decoder core. One bank fills while the other
// drains, and only complete frames are released with sof/eof markers.
// Optional build macro: FEC_DEC_BUF_OVF_DROP_EN. When defined, the input is
// never backpressured; words arriving while the write bank is occupied are
// dropped and a sticky overflow flag is raised.
module fec_dec_pingpong_buffer #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [1:0]        bank_full,
  output logic              overflow
);

  localparam int ADDR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'b00,
    BANK_FULL     = 2'b01,
    BANK_DRAINING = 2'b10
  } bank_state_e;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];

  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eof_q, out_eof_d;

  logic [DATA_W-1:0] mem_q [2][FRAME_LEN];

  logic wr_bank_free;
  logic wr_accept;
  logic rd_load;

  assign wr_bank_free = (bank_q[wr_bank_q] == BANK_EMPTY);
  assign wr_accept    = in_valid & wr_bank_free;
  assign rd_load      = (!out_valid_q | out_ready) & (bank_q[rd_bank_q] != BANK_EMPTY);

  // Frame storage: plain registers, contents are only meaningful via bank state
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_bank_q][wr_addr_q] <= in_data;
    end
  end

  // Next-state for bank states, pointers and the output register
  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;

    if (wr_accept) begin
      if (wr_addr_q == LAST_ADDR) begin
        bank_d[wr_bank_q] = BANK_FULL;
        wr_addr_d         = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
    end

    if (rd_load) begin
      out_data_d  = mem_q[rd_bank_q][rd_addr_q];
      out_sof_d   = (rd_addr_q == '0);
      out_eof_d   = (rd_addr_q == LAST_ADDR);
      out_valid_d = 1'b1;
      if (rd_addr_q == LAST_ADDR) begin
        bank_d[rd_bank_q] = BANK_EMPTY;
        rd_addr_d         = '0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        bank_d[rd_bank_q] = BANK_DRAINING;
        rd_addr_d         = rd_addr_q + ADDR_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output registers; reset discards all stored and partial frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

`ifdef FEC_DEC_BUF_OVF_DROP_EN
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q | (in_valid & !wr_bank_free);

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign in_ready = rst_n;
  assign overflow = overflow_q;
`else
  assign in_ready = rst_n & wr_bank_free;
  assign overflow = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign bank_full = {bank_q[1] != BANK_EMPTY, bank_q[0] != BANK_EMPTY};

endmodule
